// File: rtl/decode_instruction.sv
// rtl/decode_instruction.sv - single-slot instruction decode stage with load-use bubble insertion
module decode_instruction #(
  parameter int WORD = 32,
  parameter int ADDR = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            v_i,
  input  logic [WORD-1:0] inst_i,
  input  logic [ADDR-1:0] pc_i,
  input  logic            stall_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            v_o,
  output logic [ADDR-1:0] pc_o,
  output logic [5:0]      op_o,
  output logic [4:0]      rd_o,
  output logic [4:0]      rs_o,
  output logic [4:0]      rt_o,
  output logic [WORD-1:0] imm_o,
  output logic            is_load_o,
  output logic            we_o,
  output logic [15:0]     hazard_cnt_o
);

  logic            r_v;
  logic [ADDR-1:0] r_pc;
  logic [5:0]      r_op;
  logic [4:0]      r_rd;
  logic [4:0]      r_rs;
  logic [4:0]      r_rt;
  logic [WORD-1:0] r_imm;
  logic            r_is_load;
  logic            r_we;
  logic [15:0]     r_hazard_cnt;

  logic [5:0]      w_op;
  logic [4:0]      w_rd;
  logic [4:0]      w_rs;
  logic [4:0]      w_rt;
  logic [WORD-1:0] w_imm;
  logic            w_is_load;
  logic            w_we;
  logic            w_hazard;

  assign w_op      = inst_i[31:26];
  assign w_rd      = inst_i[25:21];
  assign w_rs      = inst_i[20:16];
  assign w_rt      = inst_i[15:11];
  assign w_imm     = {{(WORD-16){inst_i[15]}}, inst_i[15:0]};
  assign w_is_load = (w_op == 6'h10);
  assign w_we      = v_i && ((w_op[5:4] == 2'b00) || w_is_load) && (w_rd != 5'd0);

  // Both source fields are compared regardless of opcode: cheap and never misses a dependency.
  assign w_hazard = v_i && r_v && r_is_load && (r_rd != 5'd0) &&
                    ((w_rs == r_rd) || (w_rt == r_rd));

  assign stall_o = stall_i || (w_hazard && !flush_i);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_v          <= 1'b0;
      r_pc         <= '0;
      r_op         <= '0;
      r_rd         <= '0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_imm        <= '0;
      r_is_load    <= 1'b0;
      r_we         <= 1'b0;
      r_hazard_cnt <= '0;
    end else if (flush_i) begin
      r_v       <= 1'b0;
      r_we      <= 1'b0;
      r_is_load <= 1'b0;
    end else if (stall_i) begin
      r_v <= r_v;
    end else if (w_hazard) begin
      // Bubble leaves v_o low, so the held instruction cannot re-trigger next cycle.
      r_v       <= 1'b0;
      r_we      <= 1'b0;
      r_is_load <= 1'b0;
      if (r_hazard_cnt != 16'hFFFF) begin
        r_hazard_cnt <= r_hazard_cnt + 16'd1;
      end
    end else begin
      r_v       <= v_i;
      r_pc      <= pc_i;
      r_op      <= w_op;
      r_rd      <= w_rd;
      r_rs      <= w_rs;
      r_rt      <= w_rt;
      r_imm     <= w_imm;
      r_is_load <= v_i && w_is_load;
      r_we      <= w_we;
    end
  end

  assign v_o          = r_v;
  assign pc_o         = r_pc;
  assign op_o         = r_op;
  assign rd_o         = r_rd;
  assign rs_o         = r_rs;
  assign rt_o         = r_rt;
  assign imm_o        = r_imm;
  assign is_load_o    = r_is_load;
  assign we_o         = r_we;
  assign hazard_cnt_o = r_hazard_cnt;

endmodule

// File: tb/tb_decode_instruction.sv
// tb/tb_decode_instruction.sv - table, directed and randomized checks of decode_instruction
module tb_decode_instruction;

  logic        clk = 1'b0;
  logic        reset;
  logic        v_i;
  logic [31:0] inst_i;
  logic [31:0] pc_i;
  logic        stall_i;
  logic        flush_i;
  logic        stall_o;
  logic        v_o;
  logic [31:0] pc_o;
  logic [5:0]  op_o;
  logic [4:0]  rd_o;
  logic [4:0]  rs_o;
  logic [4:0]  rt_o;
  logic [31:0] imm_o;
  logic        is_load_o;
  logic        we_o;
  logic [15:0] hazard_cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_instruction #(.WORD(32), .ADDR(32)) dut (
    .clk(clk), .reset(reset), .v_i(v_i), .inst_i(inst_i), .pc_i(pc_i),
    .stall_i(stall_i), .flush_i(flush_i), .stall_o(stall_o), .v_o(v_o),
    .pc_o(pc_o), .op_o(op_o), .rd_o(rd_o), .rs_o(rs_o), .rt_o(rt_o),
    .imm_o(imm_o), .is_load_o(is_load_o), .we_o(we_o), .hazard_cnt_o(hazard_cnt_o)
  );

  typedef struct {
    bit          rst;
    bit          v;
    logic [31:0] inst;
    logic [31:0] pc;
    bit          st;
    bit          fl;
    bit          e_so;
    bit          e_v;
    bit          e_we;
    bit          e_ld;
    logic [31:0] e_pc;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input int op, input int rd, input int rs, input int imm16);
    mk = {6'(op), 5'(rd), 5'(rs), 16'(imm16)};
  endfunction

  function automatic vec_t row(input bit rst, input bit v, input logic [31:0] inst, input int pc,
                               input bit st, input bit fl, input bit e_so, input bit e_v,
                               input bit e_we, input bit e_ld, input int e_pc, input int e_cnt);
    row = '{rst, v, inst, 32'(pc), st, fl, e_so, e_v, e_we, e_ld, 32'(e_pc), 16'(e_cnt)};
  endfunction

  task automatic drive(input bit rst, input bit v, input logic [31:0] inst, input logic [31:0] pc,
                       input bit st, input bit fl);
    reset = rst; v_i = v; inst_i = inst; pc_i = pc; stall_i = st; flush_i = fl;
  endtask

  task automatic run_vec(input vec_t t, input int idx);
    drive(t.rst, t.v, t.inst, t.pc, t.st, t.fl);
    #1;
    chk($sformatf("tbl%0d stall_o", idx), 32'(stall_o), 32'(t.e_so));
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("tbl%0d v_o", idx), 32'(v_o), 32'(t.e_v));
    chk($sformatf("tbl%0d we_o", idx), 32'(we_o), 32'(t.e_we));
    chk($sformatf("tbl%0d is_load_o", idx), 32'(is_load_o), 32'(t.e_ld));
    chk($sformatf("tbl%0d hazard_cnt_o", idx), 32'(hazard_cnt_o), 32'(t.e_cnt));
    if (t.e_v) chk($sformatf("tbl%0d pc_o", idx), pc_o, t.e_pc);
  endtask

  // Reference model state: the decoded slot as the spec describes it.
  bit          m_v, m_we, m_ld;
  logic [31:0] m_pc, m_imm;
  int          m_op, m_rd, m_rs, m_rt;
  int          m_cnt;

  function automatic bit model_hazard(input bit v, input logic [31:0] inst);
    int rs = int'(inst[20:16]);
    int rt = int'(inst[15:11]);
    return v && m_v && m_ld && (m_rd != 0) && (rs == m_rd || rt == m_rd);
  endfunction

  task automatic model_step(input bit rst, input bit v, input logic [31:0] inst,
                            input logic [31:0] pc, input bit st, input bit fl);
    int op = int'(inst[31:26]);
    int rd = int'(inst[25:21]);
    bit hz = model_hazard(v, inst);
    if (rst) begin
      m_v = 0; m_we = 0; m_ld = 0; m_pc = 0; m_imm = 0;
      m_op = 0; m_rd = 0; m_rs = 0; m_rt = 0; m_cnt = 0;
    end else if (fl) begin
      m_v = 0; m_we = 0; m_ld = 0;
    end else if (st) begin
      m_v = m_v;
    end else if (hz) begin
      m_v = 0; m_we = 0; m_ld = 0;
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
    end else begin
      m_v  = v;
      m_pc = pc;
      m_op = op;
      m_rd = rd;
      m_rs = int'(inst[20:16]);
      m_rt = int'(inst[15:11]);
      m_imm = 32'(int'($signed(inst[15:0])));
      m_ld = v && (op == 16);
      m_we = v && (op < 16 || op == 16) && (rd != 0);
    end
  endtask

  initial begin
    int stalls;
    bit rst, v, st, fl, prev_so, exp_so;
    logic [31:0] inst, pc;
    int ops[6] = '{1, 15, 16, 16, 32, 63};

    tbl.push_back(row(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
    tbl.push_back(row(0, 1, mk(1, 3, 0, 0), 5, 0, 0,  0, 1, 1, 0, 5, 0));
    tbl.push_back(row(0, 1, mk(16, 4, 0, 0), 6, 0, 0,  0, 1, 1, 1, 6, 0));
    tbl.push_back(row(0, 1, mk(1, 5, 4, 0), 7, 0, 0,  1, 0, 0, 0, 0, 1));
    tbl.push_back(row(0, 1, mk(1, 5, 4, 0), 7, 0, 0,  0, 1, 1, 0, 7, 1));
    tbl.push_back(row(0, 1, mk(16, 0, 0, 0), 8, 0, 0,  0, 1, 0, 1, 8, 1));
    tbl.push_back(row(0, 1, mk(1, 2, 0, 0), 9, 0, 0,  0, 1, 1, 0, 9, 1));
    tbl.push_back(row(0, 1, mk(1, 7, 1, 0), 10, 1, 0,  1, 1, 1, 0, 9, 1));
    tbl.push_back(row(0, 1, mk(1, 7, 1, 0), 10, 1, 0,  1, 1, 1, 0, 9, 1));
    tbl.push_back(row(0, 1, mk(1, 7, 1, 0), 10, 1, 0,  1, 1, 1, 0, 9, 1));
    tbl.push_back(row(0, 1, mk(1, 7, 1, 0), 10, 1, 1,  1, 0, 0, 0, 0, 1));
    tbl.push_back(row(0, 1, mk(16, 6, 0, 0), 11, 0, 0,  0, 1, 1, 1, 11, 1));
    tbl.push_back(row(0, 1, mk(1, 2, 0, 6 << 11), 12, 0, 1,  0, 0, 0, 0, 0, 1));
    tbl.push_back(row(0, 0, mk(1, 2, 0, 0), 0, 0, 0,  0, 0, 0, 0, 0, 1));
    tbl.push_back(row(0, 1, mk(32, 7, 0, 0), 13, 0, 0,  0, 1, 0, 0, 13, 1));
    tbl.push_back(row(0, 0, mk(16, 3, 0, 0), 0, 0, 0,  0, 0, 0, 0, 0, 1));
    tbl.push_back(row(0, 1, mk(16, 3, 0, 0), 14, 0, 0,  0, 1, 1, 1, 14, 1));
    tbl.push_back(row(1, 1, mk(1, 1, 3, 0), 15, 1, 0,  1, 0, 0, 0, 0, 0));

    drive(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    foreach (tbl[i]) run_vec(tbl[i], i);

    // Randomized run against the reference model; upstream honours stall_o.
    model_step(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    prev_so = 0; v = 0; inst = 0; pc = 0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (!prev_so) begin
        v    = ($urandom_range(0, 3) != 0);
        inst = {6'(ops[$urandom_range(0, 5)]), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 11'($urandom)};
        pc   = $urandom;
      end
      st = ($urandom_range(0, 5) == 0);
      fl = ($urandom_range(0, 9) == 0);
      drive(rst, v, inst, pc, st, fl);
      exp_so = st || (model_hazard(v, inst) && !fl);
      #1;
      chk("rnd stall_o", 32'(stall_o), 32'(exp_so));
      model_step(rst, v, inst, pc, st, fl);
      prev_so = exp_so && !rst;
      @(posedge clk);
      @(negedge clk);
      chk("rnd v_o", 32'(v_o), 32'(m_v));
      chk("rnd we_o", 32'(we_o), 32'(m_we));
      chk("rnd is_load_o", 32'(is_load_o), 32'(m_ld));
      chk("rnd hazard_cnt_o", 32'(hazard_cnt_o), 32'(m_cnt));
      if (m_v) begin
        chk("rnd pc_o", pc_o, m_pc);
        chk("rnd op_o", 32'(op_o), 32'(m_op));
        chk("rnd rd_o", 32'(rd_o), 32'(m_rd));
        chk("rnd rs_o", 32'(rs_o), 32'(m_rs));
        chk("rnd rt_o", 32'(rt_o), 32'(m_rt));
        chk("rnd imm_o", imm_o, m_imm);
      end
    end

    // Saturation: preload the counter near the top, then keep generating load-use hazards.
    drive(1, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    force dut.r_hazard_cnt = 16'hFFFD;
    #1;
    release dut.r_hazard_cnt;
    stalls = 0;
    for (int c = 0; c < 8; c++) begin
      drive(0, 1, mk(16, 1, 1, 16'h8001), 32'h40, 0, 0);
      #1;
      if (stall_o) stalls++;
      @(posedge clk);
      @(negedge clk);
    end
    chk("sat stall count", 32'(stalls), 32'd4);
    chk("sat hazard_cnt_o", 32'(hazard_cnt_o), 32'hFFFF);

    drive(1, 1, mk(16, 1, 1, 16'h8001), 32'h44, 1, 1);
    @(posedge clk);
    @(negedge clk);
    chk("rst v_o", 32'(v_o), 0);
    chk("rst we_o", 32'(we_o), 0);
    chk("rst is_load_o", 32'(is_load_o), 0);
    chk("rst pc_o", pc_o, 0);
    chk("rst fields", {op_o, rd_o, rs_o, rt_o}, 0);
    chk("rst imm_o", imm_o, 0);
    chk("rst hazard_cnt_o", 32'(hazard_cnt_o), 0);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("post-rst stall_o", 32'(stall_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
